// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU request arbiter: opcodes, FSM states, flag bit positions.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    INC  = 4'd2,
    DEC  = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    NOTA = 4'd6,
    NOTB = 4'd7,
    NAND = 4'd8,
    XOR  = 4'd9,
    XNOR = 4'd10,
    SLL  = 4'd11,
    SRL  = 4'd12,
    SLT  = 4'd13,
    GE   = 4'd14
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_e;

  // Bit positions inside the 4-bit {C,O,S,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_C = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request above 'last', wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDXW  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  last_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             valid_o
);

  // Scan last+1 .. last+N_REQ (mod N_REQ); last itself is checked last
  always_comb begin
    int j;
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    j        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_i) + k) % N_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        winner_o[j] = 1'b1;
        idx_o       = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external ALU among N_REQ requesters: grant in IDLE, capture result in EXEC.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int N_REQ = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [4*N_REQ-1:0]     cntrl_i,
  input  logic [WIDTH*N_REQ-1:0] a_i,
  input  logic [WIDTH*N_REQ-1:0] b_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [WIDTH-1:0]       result_o,
  output logic [3:0]             flag_o,
  output logic                   busy_o,
  output logic [3:0]             alu_cntrl_o,
  output logic [WIDTH-1:0]       alu_a_o,
  output logic [WIDTH-1:0]       alu_b_o,
  input  logic [WIDTH-1:0]       alu_result_i,
  input  logic [3:0]             alu_flag_i
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q;
  logic [IDXW-1:0]  last_q, widx_q;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q, a_q, b_q;
  logic [3:0]       flag_q, cntrl_q;

  logic [N_REQ-1:0] win_oh;
  logic [IDXW-1:0]  win_idx;
  logic             win_vld;
  int               wsel;

  rr_arbiter #(.N_REQ(N_REQ), .IDXW(IDXW)) u_rr (
    .req_i   (req_i),
    .last_i  (last_q),
    .winner_o(win_oh),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  assign wsel = int'(win_idx);

  // Two-state controller; every output is a register so the ALU sees stable operands
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      last_q   <= IDXW'(N_REQ - 1);
      widx_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= '0;
      cntrl_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (win_vld) begin
            // Operands are latched here so the requester is free to change them next cycle
            cntrl_q <= cntrl_i[4*wsel +: 4];
            a_q     <= a_i[WIDTH*wsel +: WIDTH];
            b_q     <= b_i[WIDTH*wsel +: WIDTH];
            gnt_q   <= win_oh;
            widx_q  <= win_idx;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // req_i is not looked at here: a dropped request still completes
          result_q <= alu_result_i;
          flag_q   <= alu_flag_i;
          done_q   <= gnt_q;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          last_q   <= widx_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign result_o    = result_q;
  assign flag_o      = flag_q;
  assign alu_cntrl_o = cntrl_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a small behavioural ALU attached.
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  localparam int W = 24;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [4*N-1:0] cntrl;
  logic [W*N-1:0] a, b;
  logic [N-1:0]   gnt_o, done_o;
  logic [W-1:0]   result_o, alu_a_o, alu_b_o, alu_res;
  logic [3:0]     flag_o, alu_cntrl_o, alu_flg;
  logic           busy_o;

  always #5 clk = ~clk;

  alu_req_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_i       (req),
    .cntrl_i     (cntrl),
    .a_i         (a),
    .b_i         (b),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .flag_o      (flag_o),
    .busy_o      (busy_o),
    .alu_cntrl_o (alu_cntrl_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_result_i(alu_res),
    .alu_flag_i  (alu_flg)
  );

  // Stand-in for the shared ALU; SUB reports a borrow on both C and O,
  // opcode 15 gives 0 with only Z set
  logic [W:0] alu_t;
  logic       alu_ov;
  always_comb begin
    alu_t  = '0;
    alu_ov = 1'b0;
    case (alu_op_e'(alu_cntrl_o))
      ADD: begin
        alu_t  = {1'b0, alu_a_o} + {1'b0, alu_b_o};
        alu_ov = (alu_a_o[W-1] == alu_b_o[W-1]) && (alu_t[W-1] != alu_a_o[W-1]);
      end
      SUB: begin
        alu_t  = {1'b0, alu_a_o} - {1'b0, alu_b_o};
        alu_ov = alu_t[W];
      end
      INC: begin
        alu_t  = {1'b0, alu_a_o} + 25'd1;
        alu_ov = !alu_a_o[W-1] && alu_t[W-1];
      end
      AND:     alu_t = {1'b0, alu_a_o & alu_b_o};
      XOR:     alu_t = {1'b0, alu_a_o ^ alu_b_o};
      default: alu_t = '0;
    endcase
    alu_res = alu_t[W-1:0];
    alu_flg = '0;
    alu_flg[FLAG_C] = alu_t[W];
    alu_flg[FLAG_O] = alu_ov;
    alu_flg[FLAG_S] = alu_res[W-1];
    alu_flg[FLAG_Z] = (alu_res == '0);
  end

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  logic [N-1:0] exp_gnt[$];
  exp_t         exp_done[$];
  int           ntests = 0;
  int           nfail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input alu_op_e op, input logic [W-1:0] av,
                        input logic [W-1:0] bv);
    cntrl[4*i +: 4] = op;
    a[W*i +: W]     = av;
    b[W*i +: W]     = bv;
  endtask

  task automatic push(input logic [N-1:0] oh, input logic [W-1:0] res, input logic [3:0] flg);
    exp_t e;
    e.oh = oh; e.res = res; e.flg = flg;
    exp_gnt.push_back(oh);
    exp_done.push_back(e);
  endtask

  // Waits (bounded) for n done pulses; returns on the negedge the last one is seen
  task automatic wait_done(input int n, input int limit, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    while (got < n && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done_o != '0) got++;
    end
    chk("done_timeout", got, n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},    gnt_o, 0);
    chk({tag, "_done"},   done_o, 0);
    chk({tag, "_busy"},   busy_o, 0);
    chk({tag, "_result"}, result_o, 0);
    chk({tag, "_flag"},   flag_o, 0);
    chk({tag, "_cntrl"},  alu_cntrl_o, 0);
    chk({tag, "_a"},      alu_a_o, 0);
    chk({tag, "_b"},      alu_b_o, 0);
  endtask

  initial begin
    int cyc, c1, c3;
    rst_n = 1'b0;
    req   = '0;
    cntrl = '0;
    a     = '0;
    b     = '0;
    #1 chk_reset_vals("reset");

    // Monitor: pops the scoreboard whenever the DUT shows a grant or a completion
    fork
      begin
        logic [N-1:0] prev_gnt, prev_done;
        exp_t e;
        prev_gnt  = '0;
        prev_done = '0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            prev_gnt  = '0;
            prev_done = '0;
          end else begin
            chk("busy_vs_gnt", busy_o, (gnt_o != '0));
            if (gnt_o != '0) begin
              if (exp_gnt.size() == 0) chk("unexpected_grant", gnt_o, 0);
              else chk("grant", gnt_o, exp_gnt.pop_front());
            end
            if (done_o != '0) begin
              chk("done_follows_gnt", done_o, prev_gnt);
              chk("done_not_back_to_back", prev_done, 0);
              if (exp_done.size() == 0) chk("unexpected_done", done_o, 0);
              else begin
                e = exp_done.pop_front();
                chk("done_oh", done_o, e.oh);
                chk("result", result_o, e.res);
                chk("flag", flag_o, e.flg);
              end
            end
            prev_gnt  = gnt_o;
            prev_done = done_o;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single ADD on requester 0
    set_op(0, ADD, 24'h000005, 24'h000003);
    push(4'b0001, 24'h000008, 4'b0000);
    req = 4'b0001;
    wait_done(1, 10, cyc);
    req = '0;
    repeat (2) @(negedge clk);

    // Fair order from reset, all four requesting
    @(negedge clk);
    #2 rst_n = 1'b0;
    set_op(0, ADD, 24'h000001, 24'h000001);
    set_op(1, SUB, 24'h00000A, 24'h000004);
    set_op(2, AND, 24'hF0F0F0, 24'h0FF0FF);
    cntrl[15:12] = 4'd15;
    a[95:72] = 24'h123456;
    b[95:72] = 24'h654321;
    req = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      push(4'b0001, 24'h000002, 4'b0000);
      push(4'b0010, 24'h000006, 4'b0000);
      push(4'b0100, 24'h00F0F0, 4'b0000);
      push(4'b1000, 24'h000000, 4'b0001);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_done(8, 40, cyc);
    req = '0;
    chk("fair_cycles", cyc, 16);
    repeat (2) @(negedge clk);

    // Alternation between 1 and 3; also SUB flags
    set_op(1, SUB, 24'h000003, 24'h000005);
    set_op(3, XOR, 24'hAAAAAA, 24'h555555);
    for (int r = 0; r < 2; r++) begin
      push(4'b0010, 24'hFFFFFE, 4'b1110);
      push(4'b1000, 24'hFFFFFF, 4'b0010);
    end
    req = 4'b1010;
    c1 = 0;
    c3 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_o[1]) c1++;
      if (done_o[3]) c3++;
    end
    req = '0;
    chk("alt_done1", c1, 2);
    chk("alt_done3", c3, 2);
    repeat (2) @(negedge clk);

    // Request dropped during EXEC; operands changed after grant
    set_op(2, INC, 24'hFFFFFF, 24'h000000);
    push(4'b0100, 24'h000000, 4'b1001);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    a[71:48] = 24'h123456;
    wait_done(1, 4, cyc);
    repeat (6) @(negedge clk);
    chk("drop_idle_gnt", gnt_o, 0);

    // Reset in the middle of EXEC: no completion, then requester 0 first
    set_op(0, ADD, 24'h000001, 24'h000002);
    exp_gnt.push_back(4'b0001);
    req = 4'b0001;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midexec");
    set_op(3, XOR, 24'h00000F, 24'h0000F0);
    req = 4'b1001;
    push(4'b0001, 24'h000003, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_done(1, 6, cyc);
    req = '0;

    repeat (4) @(negedge clk);
    chk("gnt_queue_empty", exp_gnt.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
